// File: rtl/fab_osc_rst_seq.sv
// Fabric reset sequencer: async-assert / sync-release of FAB_RESET_N after a startup delay,
// plus crystal qualification by edge counting when FAB_OSC_RST_SEQ_XTL_MON_EN is defined.
module fab_osc_rst_seq #(
    parameter int unsigned STARTUP_CYCLES = 1024,
    parameter int unsigned XTL_WINDOW     = 50000,
    parameter int unsigned XTL_MIN_EDGES  = 30,
    parameter int unsigned XTL_MAX_EDGES  = 36,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        XTL_IN,
    input  logic        SW_RST_REQ,
    output logic        FAB_RESET_N,
    output logic        READY,
    output logic        XTL_FAIL,
    output logic [15:0] EDGE_COUNT
);

    localparam logic [2:0]  RST_HOLD     = 3'd0;
    localparam logic [2:0]  STARTUP      = 3'd1;
    localparam logic [2:0]  MEASURE      = 3'd2;
    localparam logic [2:0]  RUN          = 3'd3;
    localparam logic [2:0]  FAIL         = 3'd4;
    localparam logic [15:0] STARTUP_LAST = 16'(STARTUP_CYCLES - 1);

    logic [2:0]  state;
    logic [15:0] startup_cnt;
    logic        restart;

    assign restart = SW_RST_REQ && (state != RST_HOLD);

`ifdef FAB_OSC_RST_SEQ_XTL_MON_EN
    localparam logic [19:0] WINDOW_LAST = 20'(XTL_WINDOW - 1);
    localparam logic [15:0] MIN_EDGES   = 16'(XTL_MIN_EDGES);
    localparam logic [15:0] MAX_EDGES   = 16'(XTL_MAX_EDGES);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev;
    logic                   xtl_rise;
    logic                   measuring;
    logic                   window_end;
    logic                   in_range;
    logic                   fail_q;
    logic [19:0]            window_cnt;
    logic [15:0]            edge_cnt;
    logic [15:0]            edge_total;
    logic [15:0]            edge_count_q;

    // Synchroniser keeps running through restarts so no false edge appears on a SW reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            sync_q    <= '0;
            sync_prev <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], XTL_IN};
            sync_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign xtl_rise   = sync_q[SYNC_STAGES-1] & ~sync_prev;
    assign measuring  = (state == MEASURE) || (state == RUN) || (state == FAIL);
    assign window_end = measuring && (window_cnt == WINDOW_LAST);
    assign edge_total = (xtl_rise && (edge_cnt != 16'hFFFF)) ? edge_cnt + 16'd1 : edge_cnt;
    assign in_range   = (edge_total >= MIN_EDGES) && (edge_total <= MAX_EDGES);

    // NOTE: restart is tested before window_end so a SW reset on the last window cycle discards that window.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            window_cnt   <= '0;
            edge_cnt     <= '0;
            edge_count_q <= '0;
        end else if (restart || !measuring) begin
            window_cnt <= '0;
            edge_cnt   <= '0;
        end else if (window_end) begin
            window_cnt   <= '0;
            edge_cnt     <= '0;
            edge_count_q <= edge_total;
        end else begin
            window_cnt <= window_cnt + 20'd1;
            edge_cnt   <= edge_total;
        end
    end

    assign EDGE_COUNT = edge_count_q;
    assign XTL_FAIL   = fail_q;
`else
    logic cfg_unused;

    assign cfg_unused = ^{XTL_IN, XTL_WINDOW, XTL_MIN_EDGES, XTL_MAX_EDGES, SYNC_STAGES, MEASURE, FAIL};
    assign EDGE_COUNT = '0;
    assign XTL_FAIL   = 1'b0;
`endif

    // NOTE: FAB_RESET_N is a flop output, so its release can only ever happen on a CLK edge.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state       <= RST_HOLD;
            startup_cnt <= '0;
            FAB_RESET_N <= 1'b0;
            READY       <= 1'b0;
`ifdef FAB_OSC_RST_SEQ_XTL_MON_EN
            fail_q      <= 1'b0;
`endif
        end else if (restart) begin
            state       <= STARTUP;
            startup_cnt <= '0;
            FAB_RESET_N <= 1'b0;
            READY       <= 1'b0;
`ifdef FAB_OSC_RST_SEQ_XTL_MON_EN
            fail_q      <= 1'b0;
`endif
        end else begin
            case (state)
                RST_HOLD: begin
                    state       <= STARTUP;
                    startup_cnt <= '0;
                end
                STARTUP: begin
                    if (startup_cnt == STARTUP_LAST) begin
                        FAB_RESET_N <= 1'b1;
`ifdef FAB_OSC_RST_SEQ_XTL_MON_EN
                        state       <= MEASURE;
`else
                        state       <= RUN;
                        READY       <= 1'b1;
`endif
                    end else begin
                        startup_cnt <= startup_cnt + 16'd1;
                    end
                end
`ifdef FAB_OSC_RST_SEQ_XTL_MON_EN
                MEASURE, RUN: begin
                    if (window_end) begin
                        if (in_range) begin
                            state <= RUN;
                            READY <= 1'b1;
                        end else begin
                            state  <= FAIL;
                            READY  <= 1'b0;
                            fail_q <= 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
